// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index, hazard FSM state and the
// per-cycle latch-control bundle produced by the hazard controller.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hz_state_t;

    localparam int HALT_DRAIN_DEF = 2;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctl_t;

    // Canonical control patterns, one per pipeline situation
    localparam hz_ctl_t CTL_NONE     = 7'b00000_00;
    localparam hz_ctl_t CTL_RUN      = 7'b11111_00;
    localparam hz_ctl_t CTL_REDIRECT = 7'b11111_11;
    localparam hz_ctl_t CTL_LOAD_USE = 7'b00111_01;
    localparam hz_ctl_t CTL_HALT     = 7'b01111_11;
    localparam hz_ctl_t CTL_BACK     = 7'b00011_00;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): hazard observations in, latch enables/flushes and counters out.
interface hazard_ctrl_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             id_uses_rt;
    logic             ex_dREN;
    logic             ex_RegWr;
    regbits_t         ex_wsel;
    logic             ex_redirect;
    logic             ex_halt;
    logic             mem_req;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_RegWr,
               ex_wsel, ex_redirect, ex_halt, mem_req,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_RegWr,
               ex_wsel, ex_redirect, ex_halt, mem_req,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. Register 0 is never a real dependency.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dREN,
    input  logic     ex_RegWr,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     lu
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_wsel == id_rs);
    assign rt_match = id_uses_rt && (ex_wsel == id_rt);
    assign lu       = ex_dREN && ex_RegWr && (ex_wsel != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, D-cache
// freezes and halt drain, with saturating stall/flush performance counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int HALT_DRAIN = HALT_DRAIN_DEF
) (
    input logic          CLK,
    input logic          nRST,
    hazard_ctrl_if.slave hz
);

    localparam int DRAIN_W = (HALT_DRAIN < 2) ? 1 : $clog2(HALT_DRAIN + 1);

    hz_state_t          state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               halt_out_q, halt_out_d;

    logic      lu;
    logic      freeze;
    hz_ctl_t   run_ctl, ctl;
    hz_state_t run_next;
    logic      run_load_drain, run_flush, flush_evt;

    hazard_detect u_detect (
        .ex_dREN    (hz.ex_dREN),
        .ex_RegWr   (hz.ex_RegWr),
        .ex_wsel    (hz.ex_wsel),
        .id_rs      (hz.id_rs),
        .id_rt      (hz.id_rt),
        .id_uses_rt (hz.id_uses_rt),
        .lu         (lu)
    );

    assign freeze = hz.mem_req && !hz.dhit;

    // RUN priority ladder below freeze; MEM_WAIT reuses it on dhit release.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        run_ctl        = CTL_BACK;
        run_next       = RUN;
        run_load_drain = 1'b0;
        run_flush      = 1'b0;
        if (hz.ihit) begin
            if (hz.ex_halt) begin
                run_ctl        = CTL_HALT;
                run_next       = DRAIN;
                run_load_drain = 1'b1;
            end else if (hz.ex_redirect) begin
                run_ctl   = CTL_REDIRECT;
                run_flush = 1'b1;
            end else if (lu) begin
                run_ctl = CTL_LOAD_USE;
            end else begin
                run_ctl = CTL_RUN;
            end
        end
    end

    always_comb begin
        ctl       = CTL_NONE;
        state_d   = state_q;
        drain_d   = drain_q;
        flush_evt = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if ((state_q == MEM_WAIT) ? !hz.dhit : freeze) begin
                    state_d = MEM_WAIT;
                end else begin
                    ctl       = run_ctl;
                    state_d   = run_next;
                    flush_evt = run_flush;
                    if (run_load_drain) drain_d = DRAIN_W'(HALT_DRAIN);
                end
            end
            DRAIN: begin
                // Only a back-end advance retires a drain slot
                if (!freeze) begin
                    ctl = CTL_BACK;
                    if (drain_q != '0) drain_d = drain_q - 1'b1;
                end
                if ((drain_q == '0) || (!freeze && drain_q == DRAIN_W'(1))) state_d = HALTED;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctl.pc_en && state_q != HALTED && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_evt && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
        halt_out_d = (state_d == HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            halt_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halt_out_q  <= halt_out_d;
        end
    end

    // Latch controls are held inactive for the whole reset window
    assign hz.pc_en      = nRST && ctl.pc_en;
    assign hz.ifid_en    = nRST && ctl.ifid_en;
    assign hz.idex_en    = nRST && ctl.idex_en;
    assign hz.exmem_en   = nRST && ctl.exmem_en;
    assign hz.memwb_en   = nRST && ctl.memwb_en;
    assign hz.ifid_flush = nRST && ctl.ifid_flush;
    assign hz.idex_flush = nRST && ctl.idex_flush;
    assign hz.halt_out   = halt_out_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control block driving the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It observes the instruction in ID, the ID/EX latch outputs consumed by EX, and the memory request in MEM. From these it generates load-use stalls, branch/jump flushes, data-cache freezes and the halt drain sequence. It also keeps saturating stall and flush performance counters.

## Interface
- Parameters: `CNT_W`, default 16, width of the performance counters. `HALT_DRAIN`, default 2, cycles for a halt in EX to retire through WB.
- `CLK` input 1: clock, rising edge.
- `nRST` input 1: asynchronous reset, active low.
- `ihit` input 1: instruction fetch valid this cycle.
- `dhit` input 1: data access complete this cycle.
- `id_rs`, `id_rt` input 5 each: source registers of the instruction in ID.
- `id_uses_rt` input 1: the ID instruction reads rt.
- `ex_dREN`, `ex_RegWr` input 1 each: ID/EX latch outputs for the instruction in EX.
- `ex_wsel` input 5: destination register of the instruction in EX.
- `ex_redirect` input 1: the branch/jump in EX is taken (PC redirect).
- `ex_halt` input 1: the instruction in EX is halt.
- `mem_req` input 1: dREN or dWEN asserted by the instruction in MEM.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` output 1 each: latch/PC update enables.
- `ifid_flush`, `idex_flush` output 1 each: load a bubble (all-zero) instead of the inputs. Honoured only when the matching enable is high.
- `halt_out` output 1: core halted.
- `stall_cnt`, `flush_cnt` output CNT_W each: performance counters.

## Operation
- The FSM has four states: RUN, MEM_WAIT, DRAIN, HALTED. The state resets to RUN.
- Definitions:
  - `freeze = mem_req & !dhit`
  - `lu = ex_dREN & ex_RegWr & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt))`
- RUN. Rules are listed in priority order; the first match applies.
  1. `freeze`: all enables 0, flushes 0, next state MEM_WAIT.
  2. `ex_halt & ihit`: `pc_en`=0, `ifid_en`=`idex_en`=1 with both flushes 1, `exmem_en`=`memwb_en`=1. Next state DRAIN, drain counter loads HALT_DRAIN.
  3. `ex_redirect & ihit`: all enables 1, `ifid_flush`=`idex_flush`=1. `flush_cnt` increments.
  4. `lu & ihit`: `pc_en`=`ifid_en`=0, `idex_en`=1 with `idex_flush`=1, `exmem_en`=`memwb_en`=1.
  5. `ihit`: all enables 1, no flush.
  6. `!ihit`: `pc_en`=`ifid_en`=`idex_en`=0, `exmem_en`=`memwb_en`=1. The back end drains while the front end waits.
- MEM_WAIT: all enables 0 while `!dhit`. On `dhit`, outputs equal RUN's evaluation of the current inputs with `freeze` forced to 0, and next state is RUN.
- DRAIN: `pc_en`=`ifid_en`=`idex_en`=0, `exmem_en`=`memwb_en`=1 (`freeze` still holds the back end). The drain counter decrements on each back-end advance. When it reaches 0, next state is HALTED.
- HALTED: all enables 0 and `halt_out`=1. The state is left only by reset.
- `stall_cnt` increments on every cycle in which `pc_en`=0 and state is not HALTED.
- Both counters saturate at all-ones and never wrap.

## Timing
- Enables and flushes are combinational from the current state and inputs, and valid in the same cycle. The latches sample them at the next rising `CLK`.
- `halt_out`, both counters and the state are registered, so they update one cycle after the triggering condition.
- Reset values: state RUN, `halt_out` 0, `stall_cnt` 0, `flush_cnt` 0, drain counter 0.
- While `nRST`=0, all enables and flushes are forced to 0.
- Reset asserted mid-DRAIN or mid-MEM_WAIT returns the block to RUN with counters cleared. No pending stall survives reset.
- Simultaneous events:
  - `ex_redirect` with `lu`: redirect wins and no stall is taken, because the ID instruction is squashed.
  - `ex_halt` with `ex_redirect`: halt wins.
  - `freeze` with any other condition: freeze wins, and the other condition is re-evaluated on release.
- A load-use stall lasts exactly one cycle when `ihit` is held. The bubble clears `ex_dREN` on the next cycle.
- `ex_wsel`=0 never causes a stall.

## Structure
- Add to `cpu_types_pkg`:
  - `hz_state_t` enum {RUN, MEM_WAIT, DRAIN, HALTED}.
  - The `regbits_t` 5-bit register-index type.
  - `HALT_DRAIN_DEF`=2.
- Sub-module `hazard_detect`: purely combinational `lu` comparator (rs/rt/wsel compare with the zero-register exclusion), reusable by a later forwarding unit.
- All sequential logic (FSM, drain counter, performance counters) lives in `hazard_ctrl`.

## Test plan
- Load-use: `ex_dREN`=1, `ex_RegWr`=1, `ex_wsel`=5, `id_rs`=5, `ihit`=1 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cnt` becomes 1. The same case with `ex_wsel`=0 → no stall.
- Branch: `ex_redirect`=1 and `lu`=1 together → `ifid_flush`=`idex_flush`=1, `pc_en`=1, `flush_cnt` becomes 1, `stall_cnt` unchanged.
- Cache miss: `mem_req`=1 with `dhit`=0 for 3 cycles, then 1 → all enables 0 for 3 cycles; on the `dhit` cycle all enables 1 and state returns to RUN; `stall_cnt`=3.
- Halt: `ex_halt`=1, `ihit`=1 → front-end flush, then 2 DRAIN cycles with `exmem_en`=`memwb_en`=1, then `halt_out`=1 and every enable 0 indefinitely.
- Saturation and reset: force `stall_cnt` to 0xFFFF and stall one more cycle → stays 0xFFFF. Drop `nRST` mid-DRAIN → state RUN, counters 0, `halt_out` 0, enables 0 while in reset.
